// File: rtl/cocofdc_spi_bridge.sv
// cocofdc_spi_bridge
//   SPI mode-0 slave driven by the AVR. Each 4-byte frame (cmd, addr[15:8],
//   addr[7:0], data) becomes one strobed access on the parallel bus feeding
//   cocofdc. Read data and the cocofdc intr[1:0] flags go back over MISO.
//   cmd 8'h00 = write, 8'h80 = read, anything else ignores the frame
//   (MISO then returns 8'hFF after byte0).
//
// Build option: define AUTOINC_EN so that bytes after byte3 repeat the access
//   at addr+1 (write: one access per byte; read: access for addr+1 launched
//   after each data byte, result returned in the next byte). Without it,
//   extra bytes cause no access and MISO returns 8'hFF.
//
// Parameters
//   SEL_HOLD  clock_50 cycles a_sel is held low per access
//   SEL_GAP   minimum clock_50 cycles a_sel stays high between accesses
//
// Ports
//   clock_50   in     50 MHz system clock (only clock)
//   reset_n    in     synchronous active-low reset
//   spi_sck    in     SPI clock (asynchronous, <= 4 MHz)
//   spi_ss_n   in     SPI slave select, active-low (asynchronous)
//   spi_mosi   in     SPI data in, MSB first
//   spi_miso   out    SPI data out, MSB first; high-Z while spi_ss_n high
//   intr[1:0]  in     cocofdc pending flags, reported in status byte
//   a_addrbus  out    access address
//   a_databus  inout  write data driven by bridge; read data sampled
//   a_rw       out    1 = read, 0 = write
//   a_sel      out    active-low access strobe
//   busy       out    access requested or in progress (including SEL_GAP)
module cocofdc_spi_bridge #(
  parameter int unsigned SEL_HOLD = 16,
  parameter int unsigned SEL_GAP  = 8
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [1:0]  intr,
  output logic [15:0] a_addrbus,
  inout  logic [7:0]  a_databus,
  output logic        a_rw,
  output logic        a_sel,
  output logic        busy
);

  localparam int unsigned CNT_MAX = (SEL_HOLD > SEL_GAP) ? SEL_HOLD : SEL_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDRH, F_ADDRL, F_DATA, F_SKIP} frame_t;
  typedef enum logic [1:0] {E_IDLE, E_SETUP, E_LOW, E_GAP} eng_t;

  logic [2:0]       sck_sync_q, sck_sync_d;
  logic [2:0]       ss_sync_q, ss_sync_d;
  logic [2:0]       mosi_sync_q, mosi_sync_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       tx_q, tx_d;
  frame_t           frame_q, frame_d;
  logic             rd_q, rd_d;
  logic [15:0]      faddr_q, faddr_d;
  logic             req_pend_q, req_pend_d;
  logic             req_rw_q, req_rw_d;
  logic [15:0]      req_addr_q, req_addr_d;
  logic [7:0]       req_data_q, req_data_d;
  eng_t             eng_q, eng_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_sel_q, a_sel_d;
  logic             a_rw_q, a_rw_d;
  logic [15:0]      a_addr_q, a_addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             drive_q, drive_d;

  logic       sck_rise, sck_fall, ss_fall, ss_rise, ss_act;
  logic       byte_done, req_set, req_rw_n, rd_load;
  logic [7:0] rx_byte, next_byte;
  logic [15:0] req_addr_n;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_fall  = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise  = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_act   = ~ss_sync_q[1];
  // MOSI is stable for half an SCK period around the rising edge, so the
  // one-cycle-older third stage is as good as the second.
  assign rx_byte  = {rx_q[6:0], mosi_sync_q[2]};

  // Synchronisers and bit receiver
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi_sck};
    ss_sync_d   = {ss_sync_q[1:0], spi_ss_n};
    mosi_sync_d = {mosi_sync_q[1:0], spi_mosi};
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    byte_done   = 1'b0;
    if (ss_fall) begin
      bit_cnt_d = '0;
    end else if (ss_act && sck_rise) begin
      rx_d      = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end
  end

  // Frame decode: requests are only raised on completed bytes, so a frame
  // aborted by ss_n rising never produces a new access.
  always_comb begin
    frame_d    = frame_q;
    rd_d       = rd_q;
    faddr_d    = faddr_q;
    req_set    = 1'b0;
    req_rw_n   = 1'b0;
    req_addr_n = faddr_q;
    if (ss_fall) begin
      frame_d = F_CMD;
    end else if (ss_rise) begin
      frame_d = F_IDLE;
    end else if (byte_done) begin
      case (frame_q)
        F_CMD: begin
          if (rx_byte == 8'h00 || rx_byte == 8'h80) begin
            frame_d = F_ADDRH;
            rd_d    = rx_byte[7];
          end else begin
            frame_d = F_SKIP;
          end
        end
        F_ADDRH: begin
          faddr_d[15:8] = rx_byte;
          frame_d       = F_ADDRL;
        end
        F_ADDRL: begin
          faddr_d[7:0] = rx_byte;
          frame_d      = F_DATA;
          if (rd_q) begin
            req_set    = 1'b1;
            req_rw_n   = 1'b1;
            req_addr_n = {faddr_q[15:8], rx_byte};
          end
        end
        F_DATA: begin
`ifdef AUTOINC_EN
          faddr_d    = faddr_q + 16'd1;
          req_set    = 1'b1;
          req_rw_n   = rd_q;
          req_addr_n = rd_q ? faddr_q + 16'd1 : faddr_q;
`else
          frame_d = F_SKIP;
          if (!rd_q) begin
            req_set    = 1'b1;
            req_rw_n   = 1'b0;
            req_addr_n = faddr_q;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Pending request holds an access until the bus engine is free
  always_comb begin
    req_pend_d = req_pend_q;
    req_rw_d   = req_rw_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    if (req_set) begin
      req_pend_d = 1'b1;
      req_rw_d   = req_rw_n;
      req_addr_d = req_addr_n;
      req_data_d = rx_byte;
    end else if (eng_q == E_IDLE) begin
      req_pend_d = 1'b0;
    end
  end

  // Bus engine: address/rw/data set up one cycle with a_sel high, SEL_HOLD
  // cycles low, then SEL_GAP cycles high (data held for the first of them).
  always_comb begin
    eng_d    = eng_q;
    cnt_d    = cnt_q;
    a_sel_d  = a_sel_q;
    a_rw_d   = a_rw_q;
    a_addr_d = a_addr_q;
    wdata_d  = wdata_q;
    drive_d  = drive_q;
    rd_load  = 1'b0;
    case (eng_q)
      E_IDLE: begin
        if (req_pend_q) begin
          a_addr_d = req_addr_q;
          a_rw_d   = req_rw_q;
          wdata_d  = req_data_q;
          drive_d  = ~req_rw_q;
          eng_d    = E_SETUP;
        end
      end
      E_SETUP: begin
        a_sel_d = 1'b0;
        cnt_d   = '0;
        eng_d   = E_LOW;
      end
      E_LOW: begin
        if (cnt_q == CNT_W'(SEL_HOLD - 1)) begin
          a_sel_d = 1'b1;
          cnt_d   = '0;
          eng_d   = E_GAP;
          rd_load = a_rw_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      E_GAP: begin
        drive_d = 1'b0;
        if (cnt_q == CNT_W'(SEL_GAP - 1)) begin
          cnt_d = '0;
          eng_d = E_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: eng_d = E_IDLE;
    endcase
  end

  // MISO shifter: the next byte is chosen at the SCK fall that ends a byte;
  // read data replaces the preloaded 8'h00 when the access finishes, which the
  // AVR's inter-byte gap guarantees is before the data byte starts.
  always_comb begin
    case (frame_q)
      F_ADDRH, F_ADDRL, F_DATA: next_byte = 8'h00;
      default:                  next_byte = 8'hFF;
    endcase
    tx_d = tx_q;
    if (ss_fall) begin
      tx_d = {6'b0, intr};
    end else if (rd_load && ss_act && frame_q == F_DATA) begin
      tx_d = a_databus;
    end else if (ss_act && sck_fall) begin
      if (bit_cnt_q == 3'd0) tx_d = next_byte;
      else                   tx_d = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      frame_q     <= F_IDLE;
      rd_q        <= 1'b0;
      faddr_q     <= '0;
      req_pend_q  <= 1'b0;
      req_rw_q    <= 1'b1;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      eng_q       <= E_IDLE;
      cnt_q       <= '0;
      a_sel_q     <= 1'b1;
      a_rw_q      <= 1'b1;
      a_addr_q    <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      frame_q     <= frame_d;
      rd_q        <= rd_d;
      faddr_q     <= faddr_d;
      req_pend_q  <= req_pend_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      eng_q       <= eng_d;
      cnt_q       <= cnt_d;
      a_sel_q     <= a_sel_d;
      a_rw_q      <= a_rw_d;
      a_addr_q    <= a_addr_d;
      wdata_q     <= wdata_d;
      drive_q     <= drive_d;
    end
  end

  // Tristate follows the raw select pin so MISO is released immediately
  assign spi_miso  = spi_ss_n ? 1'bz : tx_q[7];
  assign a_databus = drive_q ? wdata_q : 8'hzz;
  assign a_addrbus = a_addr_q;
  assign a_rw      = a_rw_q;
  assign a_sel     = a_sel_q;
  assign busy      = (eng_q != E_IDLE) || req_pend_q;

endmodule

// File: tb/tb_cocofdc_spi_bridge.sv
// Directed testbench for cocofdc_spi_bridge: acts as the AVR SPI master and
// as the cocofdc bus model, logging every a_sel pulse for later checking.
module tb_cocofdc_spi_bridge;

  localparam int SEL_HOLD = 16;
  localparam int SEL_GAP  = 8;
  localparam int HALF     = 10;  // clk cycles per SCK half period
  localparam int BGAP     = 40;  // clk cycles between bytes
`ifdef AUTOINC_EN
  localparam int AINC = 1;
`else
  localparam int AINC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, sck, ss_n, mosi;
  wire         miso;
  logic [1:0]  intr;
  logic [15:0] addr;
  wire  [7:0]  dbus;
  logic        rw, sel, busy;
  logic        probe;
  logic [7:0]  rd_val;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  // Bus model: returns rd_val during read strobes; probe drives a marker
  // value used to confirm the bridge has released the bus.
  assign dbus = probe ? 8'hC3 : ((!sel && rw) ? rd_val : 8'hzz);

  cocofdc_spi_bridge #(.SEL_HOLD(SEL_HOLD), .SEL_GAP(SEL_GAP)) dut (
    .clock_50 (clk),
    .reset_n  (reset_n),
    .spi_sck  (sck),
    .spi_ss_n (ss_n),
    .spi_mosi (mosi),
    .spi_miso (miso),
    .intr     (intr),
    .a_addrbus(addr),
    .a_databus(dbus),
    .a_rw     (rw),
    .a_sel    (sel),
    .busy     (busy)
  );

  // a_sel pulse monitor
  int unsigned cyc = 0, pulse_cnt = 0, low_len = 0, high_run = 0;
  int unsigned rise_cyc = 0, busy_delay = 0;
  logic [15:0] log_addr [0:15];
  logic [7:0]  log_data [0:15];
  logic        log_rw   [0:15];
  int unsigned log_len  [0:15];
  int unsigned log_gap  [0:15];
  logic        stable_ok = 1'b0, setup_ok = 1'b0, hold_ok = 1'b0;
  logic        sel_prev = 1'b1, busy_prev = 1'b0, prev_rw = 1'b1, cap_rw = 1'b1;
  logic [15:0] prev_addr = '0, cap_addr = '0;
  logic [7:0]  prev_data = '0, cap_data = '0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sel_prev  <= sel;
    busy_prev <= busy;
    prev_addr <= addr;
    prev_data <= dbus;
    prev_rw   <= rw;
    if (!sel && sel_prev) begin
      if (pulse_cnt < 16) begin
        log_addr[pulse_cnt] <= addr;
        log_data[pulse_cnt] <= dbus;
        log_rw[pulse_cnt]   <= rw;
        log_gap[pulse_cnt]  <= high_run;
      end
      pulse_cnt <= pulse_cnt + 1;
      low_len   <= 1;
      stable_ok <= 1'b1;
      setup_ok  <= (prev_addr == addr) && (prev_rw == rw) && (rw || prev_data == dbus);
      cap_addr  <= addr;
      cap_data  <= dbus;
      cap_rw    <= rw;
    end else if (!sel) begin
      low_len <= low_len + 1;
      if (addr != cap_addr || rw != cap_rw || (!rw && dbus != cap_data)) stable_ok <= 1'b0;
    end
    if (sel && !sel_prev) begin
      if (pulse_cnt >= 1 && pulse_cnt <= 16) log_len[pulse_cnt-1] <= low_len;
      rise_cyc <= cyc;
      hold_ok  <= (addr == cap_addr) && (rw == cap_rw) && (rw || dbus == cap_data);
    end
    if (sel) high_run <= sel_prev ? high_run + 1 : 1;
    if (!busy && busy_prev) busy_delay <= cyc - rise_cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI mode 0 master: MOSI set half a period before each rising edge,
  // MISO sampled on the rising edge. mo/mi hold byte0 in bits [39:32].
  task automatic spi_frame(input logic [39:0] mo, input int nbits, output logic [39:0] mi);
    mi   = '0;
    ss_n = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0 && i % 8 == 0) repeat (BGAP) @(negedge clk);
      mosi = mo[39-i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      mi[39-i] = miso;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [39:0] mi;
    int unsigned p0;
    reset_n = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    intr = 2'b00; probe = 1'b0; rd_val = 8'h5A;
    repeat (4) @(negedge clk);
    check("rst_sel",  32'(sel),  32'h1);
    check("rst_rw",   32'(rw),   32'h1);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    probe = 1'b1;
    @(negedge clk);
    check("rst_dbus_released", 32'(dbus), 32'hC3);
    probe = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: write 00 12 34 A5
    p0 = pulse_cnt;
    spi_frame({8'h00, 8'h12, 8'h34, 8'hA5, 8'h00}, 32, mi);
    repeat (100) @(negedge clk);
    check("wr_pulses", pulse_cnt, p0 + 1);
    check("wr_len",    log_len[p0], SEL_HOLD);
    check("wr_addr",   32'(log_addr[p0]), 32'h1234);
    check("wr_rw",     32'(log_rw[p0]), 32'h0);
    check("wr_data",   32'(log_data[p0]), 32'hA5);
    check("wr_stable", 32'(stable_ok), 32'h1);
    check("wr_setup",  32'(setup_ok), 32'h1);
    check("wr_hold",   32'(hold_ok), 32'h1);
    check("wr_busy_gap", busy_delay, SEL_GAP);
    check("wr_miso",   mi[39:8], 32'h0000_0000);

    // 2: read 80 00 11 00 with intr=01
    intr = 2'b01;
    p0 = pulse_cnt;
    spi_frame({8'h80, 8'h00, 8'h11, 8'h00, 8'h00}, 32, mi);
    repeat (100) @(negedge clk);
    check("rd_pulses", pulse_cnt, p0 + 1 + AINC);
    check("rd_addr",   32'(log_addr[p0]), 32'h0011);
    check("rd_rw",     32'(log_rw[p0]), 32'h1);
    check("rd_len",    log_len[p0], SEL_HOLD);
    check("rd_miso_b0",  32'(mi[39:32]), 32'h01);
    check("rd_miso_b12", 32'(mi[31:16]), 32'h0000);
    check("rd_miso_b3",  32'(mi[15:8]), 32'h5A);

    // 3: illegal command with intr=10
    intr = 2'b10;
    p0 = pulse_cnt;
    spi_frame({8'h41, 8'h12, 8'h34, 8'h56, 8'h00}, 32, mi);
    repeat (100) @(negedge clk);
    check("ill_miso_b0",  32'(mi[39:32]), 32'h02);
    check("ill_miso_b13", 32'(mi[31:8]), 32'hFFFFFF);
    check("ill_pulses",   pulse_cnt, p0);
    check("ill_busy",     32'(busy), 32'h0);
    intr = 2'b00;

    // 4a: abort after 12 bits
    p0 = pulse_cnt;
    spi_frame({8'h00, 8'h12, 8'h34, 8'hA5, 8'h00}, 12, mi);
    repeat (100) @(negedge clk);
    check("abort_pulses", pulse_cnt, p0);
    check("abort_busy",   32'(busy), 32'h0);

    // 4b: reset while a_sel is low
    fork
      spi_frame({8'h00, 8'h56, 8'h78, 8'h9C, 8'h00}, 32, mi);
      begin : rst_proc
        int unsigned k;
        k = 0;
        while (sel === 1'b1 && k < 3000) begin
          @(negedge clk);
          k++;
        end
        check("rst_wait_sel_low", 32'(k < 3000), 32'h1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        probe   = 1'b1;
        @(negedge clk);
        check("midrst_sel",  32'(sel),  32'h1);
        check("midrst_rw",   32'(rw),   32'h1);
        check("midrst_addr", 32'(addr), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_dbus_released", 32'(dbus), 32'hC3);
        probe   = 1'b0;
        reset_n = 1'b1;
      end
    join
    repeat (50) @(negedge clk);

    // 5: back-to-back writes
    p0 = pulse_cnt;
    spi_frame({8'h00, 8'h00, 8'h10, 8'h01, 8'h00}, 32, mi);
    spi_frame({8'h00, 8'h00, 8'h10, 8'h02, 8'h00}, 32, mi);
    repeat (100) @(negedge clk);
    check("b2b_pulses", pulse_cnt, p0 + 2);
    check("b2b_data0",  32'(log_data[p0]), 32'h01);
    check("b2b_addr1",  32'(log_addr[p0+1]), 32'h0010);
    check("b2b_data1",  32'(log_data[p0+1]), 32'h02);
    check("b2b_gap",    32'(log_gap[p0+1] >= SEL_GAP), 32'h1);
    check("b2b_len1",   log_len[p0+1], SEL_HOLD);

    // 6: extra byte after data slot, address FFFF
    p0 = pulse_cnt;
    spi_frame({8'h00, 8'hFF, 8'hFF, 8'h11, 8'h22}, 40, mi);
    repeat (100) @(negedge clk);
    check("ext_pulses", pulse_cnt, p0 + 1 + AINC);
    check("ext_addr0",  32'(log_addr[p0]), 32'hFFFF);
    check("ext_data0",  32'(log_data[p0]), 32'h11);
    check("ext_miso_b3", 32'(mi[15:8]), 32'h00);
`ifdef AUTOINC_EN
    check("ext_addr1",  32'(log_addr[p0+1]), 32'h0000);
    check("ext_data1",  32'(log_data[p0+1]), 32'h22);
    check("ext_miso_b4", 32'(mi[7:0]), 32'h00);
`else
    check("ext_miso_b4", 32'(mi[7:0]), 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
